// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module : keypad_pkg
// Brief  : Shared types, key legend and helpers for the 4x4 keypad scanner.
// Rev    : 1.0
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Pmod KYPD legend, indexed by col*4+row
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    typedef enum logic [0:0] {
        S_DRIVE = 1'b0,
        S_EVAL  = 1'b1
    } state_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_debouncer.sv
`default_nettype none
// ============================================================================
// Module : frame_debouncer
// Brief  : Accepts a 16-bit key frame once it repeats DEBOUNCE_FRAMES times.
// Rev    : 1.0
// ============================================================================
module frame_debouncer #(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] frame,
    input  logic        eval,
    output logic [15:0] pressed,
    output logic [15:0] new_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [15:0]      last_frame_q, last_frame_d;
    logic [15:0]      pressed_q,    pressed_d;

    always_comb begin
        stable_cnt_d = stable_cnt_q;
        last_frame_d = last_frame_q;
        pressed_d    = pressed_q;
        new_press    = '0;
        if (eval) begin
            if (frame == last_frame_q) begin
                stable_cnt_d = (stable_cnt_q == CNT_MAX) ? stable_cnt_q
                                                         : stable_cnt_q + CNT_W'(1);
            end else begin
                stable_cnt_d = CNT_W'(1);
            end
            last_frame_d = frame;
            // new_press is only meaningful on the eval that accepts a changed map
            if (stable_cnt_d == CNT_MAX && frame != pressed_q) begin
                pressed_d = frame;
                new_press = frame & ~pressed_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt_q <= '0;
            last_frame_q <= '0;
            pressed_q    <= '0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
            last_frame_q <= last_frame_d;
            pressed_q    <= pressed_d;
        end
    end

    assign pressed = pressed_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : keypad_scanner
// Brief  : 4x4 matrix keypad scanner with frame debounce, key events and history.
// Rev    : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_PERIOD     = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] pressed,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [3:0]  key_hex,
    output logic [31:0] history
);

    localparam int DWELL_W = $clog2(SCAN_PERIOD);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_PERIOD - 1);
    localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

    logic [NUM_ROWS-1:0]   row_meta_q, row_meta_d;
    logic [NUM_ROWS-1:0]   row_sync_q, row_sync_d;
    state_t                state_q, state_d;
    logic [1:0]            col_q, col_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            col_n_q, col_n_d;
    logic                  key_valid_q, key_valid_d;
    logic [3:0]            key_code_q, key_code_d;
    logic [3:0]            key_hex_q, key_hex_d;
    logic [31:0]           history_q, history_d;
    logic                  eval;
    logic [15:0]           pressed_w;
    logic [15:0]           new_press;

    frame_debouncer #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame_q),
        .eval      (eval),
        .pressed   (pressed_w),
        .new_press (new_press)
    );

    always_comb begin
        row_meta_d  = row_n;
        row_sync_d  = row_meta_q;
        state_d     = state_q;
        col_d       = col_q;
        dwell_d     = dwell_q;
        frame_d     = frame_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_hex_d   = key_hex_q;
        history_d   = history_q;
        eval        = 1'b0;
        case (state_q)
            S_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    frame_d[{col_q, 2'b00} +: NUM_ROWS] = ~row_sync_q;
                    if (col_q == 2'd3) begin
                        col_d   = 2'd0;
                        state_d = S_EVAL;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            S_EVAL: begin
                // column 0 is already driven here, so its dwell overlaps this cycle
                eval    = 1'b1;
                state_d = S_DRIVE;
                if (new_press != '0) begin
                    key_valid_d = 1'b1;
                    key_code_d  = lowest_set(new_press);
                    key_hex_d   = KEY_MAP[key_code_d];
                    history_d   = {history_q[27:0], key_hex_d};
                end
            end
            default: state_d = S_DRIVE;
        endcase
        col_n_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            state_q     <= S_DRIVE;
            col_q       <= 2'd0;
            dwell_q     <= '0;
            frame_q     <= '0;
            col_n_q     <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_hex_q   <= 4'h0;
            history_q   <= '0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            state_q     <= state_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            frame_q     <= frame_d;
            col_n_q     <= col_n_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_hex_q   <= key_hex_d;
            history_q   <= history_d;
        end
    end

    assign col_n     = col_n_q;
    assign pressed   = pressed_w;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_hex   = key_hex_q;
    assign history   = history_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_scanner
// Brief  : Self-checking bench for keypad_scanner with a keypad model and a
//          frame-level reference model of debounce, events and history.
// Rev    : 1.0
// ============================================================================
module tb_keypad_scanner;

    localparam int SP = 4;
    localparam int DF = 3;
    localparam int FL = 4 * SP + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] pressed;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  key_hex;
    logic [31:0] history;
    logic [15:0] keys = '0;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    logic [15:0] m_pressed;
    logic [15:0] m_last;
    int          m_run;
    logic [3:0]  m_code;
    logic [3:0]  m_hex;
    logic [31:0] m_hist;
    int          legend [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    keypad_scanner #(
        .SCAN_PERIOD     (SP),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .pressed   (pressed),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_hex   (key_hex),
        .history   (history)
    );

    always #5 clk = ~clk;

    // Ideal keypad: a held key pulls its row low while its column is driven low
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_n[c] && keys[c*4+r]) row_n[r] = 1'b0;
            end
        end
    end

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pressed = '0;
        m_last    = '0;
        m_run     = 0;
        m_code    = '0;
        m_hex     = '0;
        m_hist    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL %s col_n got=%b exp=1110", tag, col_n); end
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL %s pressed got=%h exp=0", tag, pressed); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL %s key_valid got=%b exp=0", tag, key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL %s key_code got=%h exp=0", tag, key_code); end
        checks++; if (key_hex !== 4'h0) begin errors++; $display("FAIL %s key_hex got=%h exp=0", tag, key_hex); end
        checks++; if (history !== 32'h0) begin errors++; $display("FAIL %s history got=%h exp=0", tag, history); end
    endtask

    // Ends on a negedge with rst low; the next posedge starts frame dwell count 1
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
    endtask

    // Holds key map k for one full frame, checking every cycle and the frame result
    task automatic run_frame(input logic [15:0] k);
        logic [15:0] nw;
        logic        exp_valid;
        int          col;
        logic [3:0]  exp_col;
        keys = k;
        for (int i = 1; i <= FL; i++) begin
            @(posedge clk);
            @(negedge clk);
            col     = (i >= 4 * SP) ? 0 : i / SP;
            exp_col = ~(4'b0001 << col);
            checks++;
            if (col_n !== exp_col) begin
                errors++; $display("FAIL col_n cycle %0d got=%b exp=%b", i, col_n, exp_col);
            end
            if (i < FL) begin
                checks++;
                if (key_valid !== 1'b0) begin
                    errors++; $display("FAIL key_valid mid-frame cycle %0d got=%b exp=0", i, key_valid);
                end
                checks++;
                if (pressed !== m_pressed) begin
                    errors++; $display("FAIL pressed mid-frame cycle %0d got=%h exp=%h", i, pressed, m_pressed);
                end
            end
        end
        exp_valid = 1'b0;
        m_run  = (k == m_last) ? m_run + 1 : 1;
        m_last = k;
        if (m_run >= DF && k != m_pressed) begin
            nw = k & ~m_pressed;
            if (nw != '0) begin
                exp_valid = 1'b1;
                m_code    = 4'(lowest(nw));
                m_hex     = 4'(legend[m_code]);
                m_hist    = {m_hist[27:0], m_hex};
            end
            m_pressed = k;
        end
        if (key_valid === 1'b1) pulses++;
        checks++; if (key_valid !== exp_valid) begin errors++; $display("FAIL key_valid frame-end got=%b exp=%b", key_valid, exp_valid); end
        checks++; if (pressed !== m_pressed) begin errors++; $display("FAIL pressed frame-end got=%h exp=%h", pressed, m_pressed); end
        checks++; if (key_code !== m_code) begin errors++; $display("FAIL key_code got=%h exp=%h", key_code, m_code); end
        checks++; if (key_hex !== m_hex) begin errors++; $display("FAIL key_hex got=%h exp=%h", key_hex, m_hex); end
        checks++; if (history !== m_hist) begin errors++; $display("FAIL history got=%h exp=%h", history, m_hist); end
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        for (int f = 0; f < n; f++) run_frame(k);
    endtask

    task automatic test_reset();
        do_reset();
        hold(16'h0, 2);
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        hold(16'h0020, 10);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL single pulses got=%0d exp=1", pulses - p0); end
        checks++; if (key_code !== 4'h5 || key_hex !== 4'h5) begin errors++; $display("FAIL single code/hex got=%h/%h exp=5/5", key_code, key_hex); end
        checks++; if (history !== 32'h5) begin errors++; $display("FAIL single history got=%h exp=00000005", history); end
        checks++; if (pressed !== 16'h0020) begin errors++; $display("FAIL single pressed got=%h exp=0020", pressed); end
        p0 = pulses;
        hold(16'h0, 2);
        checks++; if (pressed !== 16'h0020) begin errors++; $display("FAIL release early pressed got=%h exp=0020", pressed); end
        hold(16'h0, 1);
        checks++; if (pressed !== 16'h0 || pulses != p0) begin errors++; $display("FAIL release pressed got=%h pulses=%0d exp=0000/%0d", pressed, pulses, p0); end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        run_frame(16'h0400); run_frame(16'h0); run_frame(16'h0400); run_frame(16'h0);
        run_frame(16'h0400); run_frame(16'h0400);
        checks++; if (pulses != p0) begin errors++; $display("FAIL bounce early pulse got=%0d exp=%0d", pulses, p0); end
        run_frame(16'h0400);
        hold(16'h0400, 3);
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL bounce pulses got=%0d exp=1", pulses - p0); end
        checks++; if (key_hex !== 4'h9 || key_code !== 4'hA) begin errors++; $display("FAIL bounce code/hex got=%h/%h exp=a/9", key_code, key_hex); end
        hold(16'h0, 3);
    endtask

    task automatic test_simultaneous();
        int p0;
        p0 = pulses;
        hold(16'h8001, 3);
        checks++; if (key_code !== 4'h0 || key_hex !== 4'h1) begin errors++; $display("FAIL simul code/hex got=%h/%h exp=0/1", key_code, key_hex); end
        checks++; if (pressed !== 16'h8001) begin errors++; $display("FAIL simul pressed got=%h exp=8001", pressed); end
        hold(16'h8000, 3);
        checks++; if (pressed !== 16'h8000) begin errors++; $display("FAIL simul release pressed got=%h exp=8000", pressed); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL simul pulses got=%0d exp=1", pulses - p0); end
        hold(16'h0, 3);
    endtask

    task automatic test_sequence();
        int idx [9] = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
        int p0;
        do_reset();
        p0 = pulses;
        for (int d = 0; d < 9; d++) begin
            hold(16'(1 << idx[d]), 3);
            hold(16'h0, 3);
            if (d == 7) begin
                checks++; if (history !== 32'h1234_5678) begin errors++; $display("FAIL seq history8 got=%h exp=12345678", history); end
            end
        end
        checks++; if (history !== 32'h2345_6789) begin errors++; $display("FAIL seq history9 got=%h exp=23456789", history); end
        checks++; if (pulses - p0 !== 9) begin errors++; $display("FAIL seq pulses got=%0d exp=9", pulses - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        hold(16'h0200, 4);
        repeat (2 * SP + 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid-reset");
        rst = 1'b0;
        model_reset();
        p0 = pulses;
        hold(16'h0200, 2);
        checks++; if (pulses != p0) begin errors++; $display("FAIL mid-reset early pulse got=%0d exp=%0d", pulses, p0); end
        run_frame(16'h0200);
        checks++; if (pulses - p0 !== 1 || key_hex !== 4'h6) begin errors++; $display("FAIL mid-reset report pulses=%0d hex=%h exp=1/6", pulses - p0, key_hex); end
        hold(16'h0, 3);
    endtask

    task automatic test_random();
        logic [15:0] k;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       k = '0;
                1, 2:    k = 16'(1 << $urandom_range(0, 15));
                default: k = 16'($urandom);
            endcase
            hold(k, $urandom_range(1, 4));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_sequence();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
